rr_arbiter_16: RTL and testbench
================================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 1, the maximum consecutive accepted grants to one requester before the pointer advances (legal range 1..8).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  16  request vector, bit i = requester i.
REQ-005 gnt_ready  input  1  downstream accepts the current grant this cycle.
REQ-006 flush  input  1  synchronous abort of the current grant.
REQ-007 gnt_valid  output  1  a grant is presented.
REQ-008 gnt_onehot  output  16  one-hot winner; all-zero when gnt_valid=0.
REQ-009 gnt_idx  output  5  winner index plus one (1..16); 0 when gnt_valid=0.

Function
REQ-010 The block SHALL hold a 4-bit rotate pointer ptr, a burst counter, a registered winner, and a 2-state FSM: IDLE, GRANT.
REQ-011 Arbitration SHALL select the first set bit of req scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
REQ-012 IDLE: if req != 0 the FSM SHALL move to GRANT with the arbitrated winner registered; req-to-gnt_valid latency is exactly 1 cycle; if req == 0 it SHALL stay in IDLE.
REQ-013 GRANT: gnt_valid=1 and gnt_onehot/gnt_idx SHALL remain stable until an accept (gnt_valid & gnt_ready), even if req changes or the winner deasserts req.
REQ-014 On accept, the burst counter SHALL increment. If req[winner]=1 in that cycle and the incremented count < MAX_BURST, the FSM SHALL stay in GRANT with the same winner.
REQ-015 Otherwise on accept: ptr SHALL become (winner+1) mod 16 and the burst counter SHALL clear. Next cycle's grant SHALL be arbitrated from the same-cycle req against the new ptr, staying in GRANT with no bubble if req != 0; if req == 0, the FSM SHALL go to IDLE.
REQ-016 With MAX_BURST=1 every accept SHALL advance ptr.
REQ-017 Wrap: winner 15 SHALL set ptr to 0; the scan SHALL wrap from bit 15 to bit 0.
REQ-018 A requester re-selected after pointer advance (sole requester) SHALL start a fresh burst count.
REQ-019 flush=1 SHALL force IDLE next cycle, gnt_valid=0, and burst counter=0, leaving ptr unchanged. flush has priority over a same-cycle accept, which SHALL NOT be counted. Arbitration in the cycle after flush follows REQ-012.
REQ-020 gnt_idx SHALL always equal the position of the single set bit of gnt_onehot plus one, and 0 when gnt_onehot is zero.
REQ-021 All outputs SHALL be driven from registers, with no combinational path from req or gnt_ready to any output.

Reset
REQ-022 While rst_n=0 the block SHALL immediately force: FSM=IDLE, ptr=0, burst counter=0, gnt_valid=0, gnt_onehot=16'h0000, gnt_idx=5'd0.
REQ-023 Reset asserted mid-GRANT SHALL drop the grant immediately with no accept recorded. The first grant after release SHALL arbitrate from ptr=0.

Verification
REQ-024 Idle: after reset, req=16'h0000 for 10 cycles -> gnt_valid=0, gnt_idx=0 every cycle.
REQ-025 Fairness, MAX_BURST=1: req=16'h8001 held, gnt_ready=1 -> gnt_idx sequence 1,16,1,16,... back-to-back with no idle cycle, starting one cycle after req.
REQ-026 Stall: grant to idx 3 presented, gnt_ready=0 for 5 cycles while req toggles (including bit 2 dropping) -> gnt_onehot=16'h0004 and gnt_idx=3 stable; an accept then occurs and ptr=3.
REQ-027 Wrap: after accept of winner 14 (idx 15) ptr=15; req=16'h4001 -> next gnt_idx=1.
REQ-028 Burst, MAX_BURST=3: req=16'h0006 held, gnt_ready=1 -> gnt_idx 2,2,2,3,3,3,2,2,2,...
REQ-029 Flush: in GRANT with idx 5, flush=1 and gnt_ready=1 in the same cycle -> next cycle gnt_valid=0 and ptr unchanged; with req=16'h0010 still held, the following cycle regrants idx 5.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// ---------------------------------------------------------------------------
// rr_arbiter_16
//   16-requester round-robin arbiter with a registered, handshaked grant and
//   optional burst hold (up to MAX_BURST consecutive accepts per winner).
//
// Parameters
//   MAX_BURST   accepts granted to one requester before the pointer moves (1..8)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         request vector, bit i = requester i
//   gnt_ready   downstream accepts the presented grant this cycle
//   flush       synchronous abort of the current grant
//   gnt_valid   a grant is presented
//   gnt_onehot  one-hot winner, zero when gnt_valid=0
//   gnt_idx     winner index plus one (1..16), zero when gnt_valid=0
// ---------------------------------------------------------------------------
module rr_arbiter_16 #(
  parameter int unsigned MAX_BURST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        gnt_ready,
  input  logic        flush,
  output logic        gnt_valid,
  output logic [15:0] gnt_onehot,
  output logic [4:0]  gnt_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  winner, winner_n;
  logic [3:0]  burst, burst_n;
  logic [3:0]  burst_inc;
  logic        accept;
  logic        hold_burst;

  // Arbitration datapath: rotate req so the scan start sits at bit 0, find the
  // lowest set bit, then rotate the offset back.
  logic [3:0]  arb_base;
  logic [31:0] req_shift;
  logic [15:0] req_rot;
  logic [3:0]  arb_offset;
  logic [3:0]  arb_win;
  logic        req_any;

  // In GRANT the only time arbitration is consumed is a pointer advance, whose
  // new pointer is winner+1; in IDLE the stored pointer is the scan start.
  assign arb_base  = (state == GRANT) ? winner + 4'd1 : ptr;
  assign req_shift = {req, req} >> arb_base;
  assign req_rot   = req_shift[15:0];
  assign req_any   = |req;

  always_comb begin
    arb_offset = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) arb_offset = 4'(i);
    end
  end

  assign arb_win = arb_base + arb_offset;

  assign accept     = (state == GRANT) && gnt_ready;
  assign burst_inc  = burst + 4'd1;
  assign hold_burst = req[winner] && (burst_inc < MAX_B);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_n  = state;
    ptr_n    = ptr;
    winner_n = winner;
    burst_n  = burst;

    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_n  = GRANT;
          winner_n = arb_win;
        end
      end
      GRANT: begin
        if (accept) begin
          if (hold_burst) begin
            burst_n = burst_inc;
          end else begin
            ptr_n   = winner + 4'd1;
            burst_n = 4'd0;
            if (req_any) winner_n = arb_win;
            else         state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort wins over a same-cycle accept: nothing is counted, pointer stays.
    if (flush) begin
      state_n  = IDLE;
      ptr_n    = ptr;
      winner_n = winner;
      burst_n  = 4'd0;
    end
  end

  // Outputs are flops loaded from the next-state values, so no input reaches
  // a port combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 4'd0;
      winner     <= 4'd0;
      burst      <= 4'd0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= 16'h0000;
      gnt_idx    <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state      <= state_n;
      ptr        <= ptr_n;
      winner     <= winner_n;
      burst      <= burst_n;
      gnt_valid  <= (state_n == GRANT);
      gnt_onehot <= (state_n == GRANT) ? (16'd1 << winner_n) : 16'h0000;
      gnt_idx    <= (state_n == GRANT) ? (5'(winner_n) + 5'd1) : 5'd0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_16
//   Self-checking bench for rr_arbiter_16. Two instances (MAX_BURST=1 and 3)
//   share stimulus; each is compared every cycle against a behavioural model
//   that arbitrates by scanning requester numbers modulo 16.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        gnt_ready;
  logic        flush;

  logic        v1, v3;
  logic [15:0] oh1, oh3;
  logic [4:0]  idx1, idx3;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_16 #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_ready(gnt_ready), .flush(flush),
    .gnt_valid(v1), .gnt_onehot(oh1), .gnt_idx(idx1)
  );

  rr_arbiter_16 #(.MAX_BURST(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_ready(gnt_ready), .flush(flush),
    .gnt_valid(v3), .gnt_onehot(oh3), .gnt_idx(idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit busy;   // a grant is presented
    int ptr;    // scan start
    int cnt;    // accepts already taken by the current winner
    int win;    // requester number of the current winner
  } model_t;

  model_t m1, m3;

  function automatic model_t model_reset();
    model_t s;
    s.busy = 0; s.ptr = 0; s.cnt = 0; s.win = 0;
    return s;
  endfunction

  function automatic int arbitrate(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++) begin
      int n;
      n = (p + k) % 16;
      if (r[n]) return n;
    end
    return 0;
  endfunction

  function automatic model_t model_next(model_t s, int max_burst,
                                        logic [15:0] r, bit rdy, bit fl);
    model_t n;
    n = s;
    if (fl) begin
      n.busy = 0;
      n.cnt  = 0;
    end else if (!s.busy) begin
      if (r != 16'h0) begin
        n.busy = 1;
        n.win  = arbitrate(r, s.ptr);
      end
    end else if (rdy) begin
      if (r[s.win] && (s.cnt + 1 < max_burst)) begin
        n.cnt = s.cnt + 1;
      end else begin
        n.ptr = (s.win + 1) % 16;
        n.cnt = 0;
        if (r != 16'h0) n.win  = arbitrate(r, n.ptr);
        else            n.busy = 0;
      end
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(string tag, logic [15:0] observed, logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs();
    check("b1_valid",  16'(v1),   16'(m1.busy));
    check("b1_onehot", oh1,       m1.busy ? (16'd1 << m1.win) : 16'h0);
    check("b1_idx",    16'(idx1), m1.busy ? 16'(m1.win + 1) : 16'h0);
    check("b3_valid",  16'(v3),   16'(m3.busy));
    check("b3_onehot", oh3,       m3.busy ? (16'd1 << m3.win) : 16'h0);
    check("b3_idx",    16'(idx3), m3.busy ? 16'(m3.win + 1) : 16'h0);
  endtask

  // One clock: model consumes the inputs held across the edge, outputs are
  // sampled 1 time unit after it. Called at posedge+1 with inputs set.
  task automatic cycle();
    model_t n1, n3;
    n1 = model_next(m1, 1, req, gnt_ready, flush);
    n3 = model_next(m3, 3, req, gnt_ready, flush);
    @(posedge clk);
    #1;
    m1 = n1;
    m3 = n3;
    check_outputs();
  endtask

  // Asserts reset mid-cycle, checks outputs drop immediately, releases away
  // from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m1 = model_reset();
    m3 = model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] STALL_PAT [5] = '{16'h0003, 16'h00f0, 16'h0000,
                                            16'hfffb, 16'h0004};

  initial begin
    rst_n     = 1'b0;
    req       = 16'h0000;
    gnt_ready = 1'b0;
    flush     = 1'b0;
    m1        = model_reset();
    m3        = model_reset();
    #1;
    do_reset();

    // Idle: no requests for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("idle_idx", 16'(idx1), 16'h0);
    end

    // Fairness with MAX_BURST=1: 1,16,1,16,... starting one cycle after req.
    req = 16'h8001; gnt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("fair_idx", 16'(idx1), (k % 2 == 0) ? 16'd1 : 16'd16);
    end
    req = 16'h0000;
    cycle(); cycle();

    // Stall: grant idx 3 held through req changes, then accepted -> ptr=3.
    do_reset();
    req = 16'h0004; gnt_ready = 1'b0;
    cycle();
    check("stall_first", 16'(idx1), 16'd3);
    for (int k = 0; k < 5; k++) begin
      req = STALL_PAT[k];
      cycle();
      check("stall_idx1", 16'(idx1), 16'd3);
      check("stall_oh1",  oh1,       16'h0004);
      check("stall_idx3", 16'(idx3), 16'd3);
    end
    req = 16'h0006; gnt_ready = 1'b1;
    cycle();
    check("stall_ptr3_b1", 16'(idx1), 16'd2);
    check("stall_hold_b3", 16'(idx3), 16'd3);
    req = 16'h0000;
    cycle(); cycle();

    // Wrap: accept of winner 14 moves ptr to 15, scan wraps to bit 0.
    do_reset();
    req = 16'h4000; gnt_ready = 1'b0;
    cycle();
    check("wrap_first", 16'(idx1), 16'd15);
    req = 16'h4001; gnt_ready = 1'b1;
    cycle();
    check("wrap_idx", 16'(idx1), 16'd1);
    req = 16'h0000;
    cycle(); cycle(); cycle();

    // Burst with MAX_BURST=3: 2,2,2,3,3,3,2,2,2.
    do_reset();
    req = 16'h0006; gnt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      check("burst_idx", 16'(idx3), (k < 3 || k >= 6) ? 16'd2 : 16'd3);
    end

    // Flush beats a same-cycle accept; regrant idx 5 one cycle later.
    do_reset();
    req = 16'h0010; gnt_ready = 1'b0;
    cycle();
    check("flush_first", 16'(idx1), 16'd5);
    flush = 1'b1; gnt_ready = 1'b1;
    cycle();
    check("flush_valid1", 16'(v1), 16'd0);
    check("flush_valid3", 16'(v3), 16'd0);
    flush = 1'b0; gnt_ready = 1'b0;
    cycle();
    check("flush_regrant", 16'(idx1), 16'd5);

    // Reset mid-grant drops the grant at once; next grant scans from 0.
    req = 16'h8001;
    do_reset();
    cycle();
    check("rst_regrant", 16'(idx1), 16'd1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 16'h0000;
        1:       req = 16'($urandom);
        default: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
      gnt_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      else                             cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
